// File: rtl/cp0_regfile_if.sv
// cp0_regfile_if: exception commit bundle, MTC0/MFC0 port and feedback to exception detection
interface cp0_regfile_if;
    logic [5:0]  hw_int;
    logic        exp_en;
    logic        exl_clean;
    logic [4:0]  exp_code;
    logic [31:0] exp_epc;
    logic        exp_bd;
    logic [31:0] exp_bad_vaddr;
    logic        exp_bad_vaddr_wen;
    logic [7:0]  exp_asid;
    logic        exp_asid_en;
    logic        mtc0_wen;
    logic [4:0]  mtc0_addr;
    logic [2:0]  mtc0_sel;
    logic [31:0] mtc0_data;
    logic [4:0]  mfc0_addr;
    logic [2:0]  mfc0_sel;
    logic [31:0] mfc0_data;
    logic [31:0] epc;
    logic [31:0] ebase;
    logic        status_bev;
    logic        cause_iv;
    logic        status_exl;
    logic        allow_interrupt;
    logic [7:0]  interrupt_flag;
    logic [7:0]  entryhi_asid;

    modport master (
        output hw_int, exp_en, exl_clean, exp_code, exp_epc, exp_bd, exp_bad_vaddr,
               exp_bad_vaddr_wen, exp_asid, exp_asid_en, mtc0_wen, mtc0_addr, mtc0_sel,
               mtc0_data, mfc0_addr, mfc0_sel,
        input  mfc0_data, epc, ebase, status_bev, cause_iv, status_exl, allow_interrupt,
               interrupt_flag, entryhi_asid
    );

    modport slave (
        input  hw_int, exp_en, exl_clean, exp_code, exp_epc, exp_bd, exp_bad_vaddr,
               exp_bad_vaddr_wen, exp_asid, exp_asid_en, mtc0_wen, mtc0_addr, mtc0_sel,
               mtc0_data, mfc0_addr, mfc0_sel,
        output mfc0_data, epc, ebase, status_bev, cause_iv, status_exl, allow_interrupt,
               interrupt_flag, entryhi_asid
    );
endinterface

// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS32r1 CP0 architectural state, timer and exception commit
module cp0_regfile #(
    parameter logic [31:0] PRID      = 32'h0001_8000,
    parameter int          COUNT_DIV = 2
) (
    input logic         clk,
    input logic         rst,
    cp0_regfile_if.slave bus
);
    logic        bev, exl, ie;
    logic [7:0]  im;
    logic        bd, ti, iv;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code;
    logic [31:0] epc_r, bad_vaddr, count, compare;
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic [17:0] ebase_base;
    logic        presc;

    logic        wr, ws0;
    logic        w_count, w_entryhi, w_compare, w_status, w_cause, w_epc, w_ebase;
    logic        tick, cnt_chg;
    logic [31:0] count_nxt;
    logic [31:0] status_v, cause_v, entryhi_v, ebase_v;
    logic        rs0;

    // An exception in the same cycle swallows any MTC0
    assign wr        = bus.mtc0_wen & ~bus.exp_en;
    assign ws0       = wr && bus.mtc0_sel == 3'd0;
    assign w_count   = ws0 && bus.mtc0_addr == 5'd9;
    assign w_entryhi = ws0 && bus.mtc0_addr == 5'd10;
    assign w_compare = ws0 && bus.mtc0_addr == 5'd11;
    assign w_status  = ws0 && bus.mtc0_addr == 5'd12;
    assign w_cause   = ws0 && bus.mtc0_addr == 5'd13;
    assign w_epc     = ws0 && bus.mtc0_addr == 5'd14;
    assign w_ebase   = wr && bus.mtc0_addr == 5'd15 && bus.mtc0_sel == 3'd1;

    assign tick      = (COUNT_DIV == 1) | presc;
    assign count_nxt = w_count ? bus.mtc0_data : count + {31'b0, tick};
    assign cnt_chg   = w_count | tick;

    // Count prescaler, Count/Compare, timer interrupt and sampled hardware interrupt lines
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc   <= 1'b0;
            count   <= 32'b0;
            compare <= 32'b0;
            ti      <= 1'b0;
            ip_hw   <= 6'b0;
        end else begin
            presc   <= (w_count || COUNT_DIV == 1) ? 1'b0 : ~presc;
            count   <= count_nxt;
            if (w_compare)
                compare <= bus.mtc0_data;
            ti      <= w_compare ? 1'b0 : ti | (cnt_chg && count_nxt == compare);
            ip_hw   <= {bus.hw_int[5] | ti, bus.hw_int[4:0]};
        end
    end

    // Exception commit takes priority over ERET, which takes priority over MTC0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bev        <= 1'b1;
            im         <= 8'b0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            bd         <= 1'b0;
            iv         <= 1'b0;
            ip_sw      <= 2'b0;
            exc_code   <= 5'b0;
            epc_r      <= 32'b0;
            bad_vaddr  <= 32'b0;
            vpn2       <= 19'b0;
            asid       <= 8'b0;
            ebase_base <= 18'b0;
        end else if (bus.exp_en) begin
            exc_code <= bus.exp_code;
            exl      <= 1'b1;
            if (!exl) begin
                epc_r <= bus.exp_epc;
                bd    <= bus.exp_bd;
            end
            if (bus.exp_bad_vaddr_wen)
                bad_vaddr <= bus.exp_bad_vaddr;
            if (bus.exp_asid_en) begin
                vpn2 <= bus.exp_bad_vaddr[31:13];
                asid <= bus.exp_asid;
            end
        end else begin
            if (w_status) begin
                bev <= bus.mtc0_data[22];
                im  <= bus.mtc0_data[15:8];
                exl <= bus.mtc0_data[1] & ~bus.exl_clean;
                ie  <= bus.mtc0_data[0];
            end else if (bus.exl_clean)
                exl <= 1'b0;
            if (w_entryhi) begin
                vpn2 <= bus.mtc0_data[31:13];
                asid <= bus.mtc0_data[7:0];
            end
            if (w_cause) begin
                iv    <= bus.mtc0_data[23];
                ip_sw <= bus.mtc0_data[9:8];
            end
            if (w_epc)
                epc_r <= bus.mtc0_data;
            if (w_ebase)
                ebase_base <= bus.mtc0_data[29:12];
        end
    end

    assign status_v  = {9'b0, bev, 6'b0, im, 6'b0, exl, ie};
    assign cause_v   = {bd, ti, 6'b0, iv, 7'b0, ip_hw, ip_sw, 1'b0, exc_code, 2'b0};
    assign entryhi_v = {vpn2, 5'b0, asid};
    assign ebase_v   = {2'b10, ebase_base, 12'b0};

    // MFC0 read mux straight from current state, no write bypass
    assign rs0 = bus.mfc0_sel == 3'd0;
    always_comb begin
        bus.mfc0_data = 32'b0;
        bus.mfc0_data = (bus.mfc0_addr == 5'd15 && bus.mfc0_sel == 3'd1) ? ebase_v :
                        !rs0                    ? 32'b0     :
                        bus.mfc0_addr == 5'd8   ? bad_vaddr :
                        bus.mfc0_addr == 5'd9   ? count     :
                        bus.mfc0_addr == 5'd10  ? entryhi_v :
                        bus.mfc0_addr == 5'd11  ? compare   :
                        bus.mfc0_addr == 5'd12  ? status_v  :
                        bus.mfc0_addr == 5'd13  ? cause_v   :
                        bus.mfc0_addr == 5'd14  ? epc_r     :
                        bus.mfc0_addr == 5'd15  ? PRID      : 32'b0;
    end

    assign bus.epc             = epc_r;
    assign bus.ebase           = ebase_v;
    assign bus.status_bev      = bev;
    assign bus.cause_iv        = iv;
    assign bus.status_exl      = exl;
    assign bus.allow_interrupt = ie & ~exl;
    assign bus.interrupt_flag  = {ip_hw, ip_sw} & im;
    assign bus.entryhi_asid    = asid;
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed checks of CP0 reset, exceptions, ERET, timer and MTC0/MFC0
module tb_cp0_regfile;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    cp0_regfile_if bus();
    cp0_regfile dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [4:0] a, input logic [2:0] s,
                          input logic [31:0] exp);
        bus.mfc0_addr = a;
        bus.mfc0_sel  = s;
        #1;
        chk(tag, bus.mfc0_data, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
        bus.mtc0_wen  = 1'b1;
        bus.mtc0_addr = a;
        bus.mtc0_sel  = s;
        bus.mtc0_data = d;
        cyc();
        bus.mtc0_wen  = 1'b0;
    endtask

    initial begin
        bus.hw_int = 6'b0;
        bus.exp_en = 1'b0;
        bus.exl_clean = 1'b0;
        bus.exp_code = 5'b0;
        bus.exp_epc = 32'b0;
        bus.exp_bd = 1'b0;
        bus.exp_bad_vaddr = 32'b0;
        bus.exp_bad_vaddr_wen = 1'b0;
        bus.exp_asid = 8'b0;
        bus.exp_asid_en = 1'b0;
        bus.mtc0_wen = 1'b0;
        bus.mtc0_addr = 5'b0;
        bus.mtc0_sel = 3'b0;
        bus.mtc0_data = 32'b0;
        bus.mfc0_addr = 5'b0;
        bus.mfc0_sel = 3'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();

        // 1: asynchronous reset mid-run
        wr(5'd9, 3'd0, 32'd5);
        chk_rd("count_loaded", 5'd9, 3'd0, 32'd5);
        rst = 1'b0;
        #1;
        chk_rd("rst_status", 5'd12, 3'd0, 32'h0040_0000);
        chk_rd("rst_count", 5'd9, 3'd0, 32'd0);
        chk("rst_ebase", bus.ebase, 32'h8000_0000);
        chk("rst_int_flag", {24'b0, bus.interrupt_flag}, 32'h0);
        chk("rst_allow", {31'b0, bus.allow_interrupt}, 32'h0);
        chk("rst_bev", {31'b0, bus.status_bev}, 32'h1);
        rst = 1'b1;

        // 2: interrupt masking and first exception
        bus.hw_int = 6'b000001;
        wr(5'd12, 3'd0, 32'h0000_0401);
        chk_rd("status_wr", 5'd12, 3'd0, 32'h0000_0401);
        chk("int_flag_ip2", {24'b0, bus.interrupt_flag}, 32'h04);
        chk("allow_ie", {31'b0, bus.allow_interrupt}, 32'h1);
        bus.exp_en = 1'b1;
        bus.exp_code = 5'd0;
        bus.exp_epc = 32'h8000_1000;
        cyc();
        bus.exp_en = 1'b0;
        chk("exc1_epc", bus.epc, 32'h8000_1000);
        chk("exc1_exl", {31'b0, bus.status_exl}, 32'h1);
        chk("exc1_allow", {31'b0, bus.allow_interrupt}, 32'h0);

        // 3: nested exception keeps EPC, then ERET with a same-cycle Status write
        bus.exp_en = 1'b1;
        bus.exp_code = 5'd4;
        bus.exp_epc = 32'h0000_1234;
        cyc();
        bus.exp_en = 1'b0;
        chk("nest_epc", bus.epc, 32'h8000_1000);
        chk_rd("nest_cause", 5'd13, 3'd0, 32'h0000_0410);
        bus.exl_clean = 1'b1;
        wr(5'd12, 3'd0, 32'h0000_0403);
        bus.exl_clean = 1'b0;
        chk("eret_exl", {31'b0, bus.status_exl}, 32'h0);
        chk_rd("eret_status", 5'd12, 3'd0, 32'h0000_0401);
        chk("eret_epc", bus.epc, 32'h8000_1000);
        chk("eret_allow", {31'b0, bus.allow_interrupt}, 32'h1);
        bus.hw_int = 6'b0;

        // 4: timer interrupt at Count == Compare with COUNT_DIV=2
        wr(5'd11, 3'd0, 32'd10);
        wr(5'd9, 3'd0, 32'd0);
        repeat (19) cyc();
        chk_rd("timer_pre_count", 5'd9, 3'd0, 32'd9);
        chk("timer_pre_ti", {31'b0, bus.mfc0_data[30]}, 32'h0);
        cyc();
        chk_rd("timer_count", 5'd9, 3'd0, 32'd10);
        chk_rd("timer_ti", 5'd13, 3'd0, 32'h4000_0010);
        cyc();
        chk_rd("timer_ip7", 5'd13, 3'd0, 32'h4000_8010);
        wr(5'd11, 3'd0, 32'd100);
        chk_rd("timer_ti_clr", 5'd13, 3'd0, 32'h0000_8010);

        // 5: TLB-style exception discards same-cycle MTC0 EPC
        bus.exp_en = 1'b1;
        bus.exp_code = 5'd2;
        bus.exp_epc = 32'h0000_5555;
        bus.exp_bad_vaddr = 32'h0040_2ABC;
        bus.exp_bad_vaddr_wen = 1'b1;
        bus.exp_asid = 8'h3C;
        bus.exp_asid_en = 1'b1;
        wr(5'd14, 3'd0, 32'h0000_DEAD);
        bus.exp_en = 1'b0;
        bus.exp_bad_vaddr_wen = 1'b0;
        bus.exp_asid_en = 1'b0;
        chk_rd("tlb_badvaddr", 5'd8, 3'd0, 32'h0040_2ABC);
        chk_rd("tlb_entryhi", 5'd10, 3'd0, 32'h0040_203C);
        chk("tlb_asid", {24'b0, bus.entryhi_asid}, 32'h3C);
        chk("tlb_epc", bus.epc, 32'h0000_5555);

        // 6: read-only fields, Count wrap, EBase, PRId, unimplemented, no bypass
        rst = 1'b0;
        #1;
        rst = 1'b1;
        wr(5'd8, 3'd0, 32'h0000_0001);
        chk_rd("badvaddr_ro", 5'd8, 3'd0, 32'h0);
        wr(5'd13, 3'd0, 32'hFFFF_FFFF);
        chk_rd("cause_wr", 5'd13, 3'd0, 32'h0080_0300);
        chk("cause_iv", {31'b0, bus.cause_iv}, 32'h1);
        wr(5'd9, 3'd0, 32'hFFFF_FFFF);
        chk_rd("wrap_max", 5'd9, 3'd0, 32'hFFFF_FFFF);
        cyc();
        chk_rd("wrap_hold", 5'd9, 3'd0, 32'hFFFF_FFFF);
        cyc();
        chk_rd("wrap_zero", 5'd9, 3'd0, 32'h0);
        chk_rd("wrap_ti", 5'd13, 3'd0, 32'h4080_0300);
        wr(5'd15, 3'd1, 32'hFFFF_FFFF);
        chk_rd("ebase_rd", 5'd15, 3'd1, 32'hBFFF_F000);
        chk("ebase_out", bus.ebase, 32'hBFFF_F000);
        chk_rd("prid", 5'd15, 3'd0, 32'h0001_8000);
        chk_rd("unimpl", 5'd16, 3'd0, 32'h0);
        chk_rd("unimpl_sel", 5'd12, 3'd2, 32'h0);
        bus.mtc0_wen = 1'b1;
        bus.mtc0_addr = 5'd14;
        bus.mtc0_sel = 3'd0;
        bus.mtc0_data = 32'h0000_ABCD;
        chk_rd("no_bypass", 5'd14, 3'd0, 32'h0);
        cyc();
        bus.mtc0_wen = 1'b0;
        chk_rd("epc_wr", 5'd14, 3'd0, 32'h0000_ABCD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 architectural state: the sequential stage directly downstream of the exception-detection logic.
- Consumes the per-cycle exception commit bundle: enable, code, EPC, BadVAddr, BD, ASID, ERET clean.
- Holds MIPS32r1 CP0 registers and serves MTC0/MFC0.
- Feeds back to exception detection: EPC, EBase, vector-select bits, interrupt enable and the masked pending-interrupt vector.

Parameters:
PRID, 32'h0001_8000, constant returned for PRId (reg 15 sel 0)
COUNT_DIV, 2, clock cycles per Count increment (1 or 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
hw_int  in  6  external interrupt lines, level, sampled each cycle
exp_en  in  1  commit an exception this cycle
exl_clean  in  1  commit ERET this cycle
exp_code  in  5  ExcCode to record
exp_epc  in  32  EPC candidate
exp_bd  in  1  branch-delay flag
exp_bad_vaddr  in  32  faulting address
exp_bad_vaddr_wen  in  1  update BadVAddr
exp_asid  in  8  ASID of faulting access
exp_asid_en  in  1  update EntryHi on TLB exception
mtc0_wen  in  1  MTC0 write strobe
mtc0_addr  in  5  register number
mtc0_sel  in  3  select
mtc0_data  in  32  write data
mfc0_addr  in  5  read register number
mfc0_sel  in  3  read select
mfc0_data  out  32  read data, combinational from current state
epc  out  32  EPC register
ebase  out  32  EBase register
status_bev  out  1  Status.BEV
cause_iv  out  1  Cause.IV
status_exl  out  1  Status.EXL
allow_interrupt  out  1  Status.IE & ~Status.EXL
interrupt_flag  out  8  Cause.IP & Status.IM
entryhi_asid  out  8  EntryHi.ASID

Behaviour:
Reset (rst low, async):
- Status=32'h0040_0000 (BEV=1).
- Cause, EPC, BadVAddr, Count, Compare and EntryHi = 0.
- EBase=32'h8000_0000.
- Count prescaler=0.
- All outputs derive from these values: interrupt_flag=0, allow_interrupt=0.

Registers (addr/sel) and writable fields; all others read 0 and ignore writes:
- BadVAddr 8/0: read-only to MTC0.
- Count 9/0: all bits.
- EntryHi 10/0: [31:13] VPN2, [7:0] ASID.
- Compare 11/0: all bits.
- Status 12/0: BEV[22], IM[15:8], EXL[1], IE[0].
- Cause 13/0: IV[23], IP[9:8]. Read-only: BD[31], TI[30], IP[15:10], ExcCode[6:2].
- EPC 14/0: all bits.
- PRId 15/0: constant.
- EBase 15/1: [29:12]; [31:30] read as 2'b10.
- Unimplemented addr/sel reads return 0.

Write latency:
- All writes take effect at the next rising edge; MFC0 in the same cycle returns the old value (no bypass).

Timer:
- Count increments by 1 every COUNT_DIV cycles, wrapping 32'hFFFF_FFFF -> 0.
- MTC0 Count loads data and clears the prescaler.
- TI is set on the edge where Count becomes equal to Compare.
- MTC0 Compare clears TI; the same-cycle equality is ignored.
- TI stays set until then.

Cause.IP[15:10]:
- Registered every cycle as {hw_int[5] | TI, hw_int[4:0]}, one-cycle latency.

Simultaneous events, priority exp_en > exl_clean > mtc0:
- exp_en=1:
  - ExcCode<=exp_code; EXL<=1.
  - If EXL was 0: EPC<=exp_epc and BD<=exp_bd. Otherwise EPC and BD are unchanged.
  - BadVAddr<=exp_bad_vaddr if exp_bad_vaddr_wen.
  - If exp_asid_en: EntryHi<={exp_bad_vaddr[31:13], 5'b0, exp_asid}.
  - A same-cycle MTC0 is discarded. exl_clean is ignored.
- exl_clean=1 (no exp_en): EXL<=0. A same-cycle MTC0 is applied, except that the EXL bit stays 0.
- Count/TI update every cycle regardless of the above.

Combinational outputs:
- interrupt_flag and allow_interrupt are purely combinational from registered state.

Test Plan:
1. Reset with rst=0 mid-run, Count=5 -> immediately Status=32'h0040_0000, Count=0, EBase=32'h8000_0000, interrupt_flag=0, allow_interrupt=0.
2. Status=32'h0000_0401 (IM2, IE), hw_int=6'b000001 -> interrupt_flag=8'h04 one cycle later, allow_interrupt=1. exp_en with code 0, epc 32'h8000_1000 -> EPC=32'h8000_1000, EXL=1, allow_interrupt=0.
3. Nested exception with EXL=1, exp_epc=32'h1234 -> EPC unchanged, ExcCode updated. Then exl_clean -> EXL=0, EPC retained.
4. Compare=10, Count=0, COUNT_DIV=2 -> TI set after 20 cycles, Cause[15]=1 next cycle. MTC0 Compare=100 -> TI=0.
5. exp_en (code 2, bad_vaddr 32'h0040_2ABC, asid 8'h3C, asid_en=1) with a same-cycle MTC0 EPC=32'hDEAD -> BadVAddr=32'h0040_2ABC, EntryHi=32'h0040_203C, EPC not DEAD.
6. MTC0 BadVAddr=1, Cause=32'hFFFF_FFFF, Count=32'hFFFF_FFFF -> BadVAddr unchanged, Cause reads 32'h0080_0300 (plus HW bits), Count wraps to 0 after COUNT_DIV cycles.
